// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential restoring divider.
//   - DIV_N     : default operand width.
//   - ST_*      : 2-bit state encodings of the divider FSM.
//   - state_t   : enumerated FSM state type built on those encodings.
//   - CNT_W     : step counter width for the default operand width.
//   - cnt_width : step counter width for any operand width n.
// ----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_N = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

  // The counter has to hold step indices 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = $clog2(DIV_N + 1);

endpackage

// File: rtl/adder_subtractor.sv
// ----------------------------------------------------------------------------
// adder_subtractor
//   Combinational W-bit adder/subtractor shared by the arithmetic datapath.
//   result = a + b when sub = 0, a - b (two's complement) when sub = 1.
//   Ports:
//     a, b   in  W  operands
//     sub    in  1  0 = add, 1 = subtract
//     result out W  sum/difference, modulo 2**W
// ----------------------------------------------------------------------------
module adder_subtractor #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] result
);

  logic [W-1:0] b_eff;

  // Subtraction is a + ~b + 1; the +1 rides in as the carry-in.
  assign b_eff  = b ^ {W{sub}};
  assign result = a + b_eff + W'(sub);

endmodule

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   The partial remainder is shifted left, taking in the next dividend bit
//   from the top of q, and the divisor is trial-subtracted N+1 bits wide.
//   A clear sign bit means the subtraction fits: keep the difference and
//   shift in a 1; otherwise restore the shifted value and shift in a 0.
//   Ports:
//     r       in  N    current partial remainder (always < d)
//     q       in  N    dividend/quotient shift register
//     d       in  N    divisor
//     r_next  out N    partial remainder after this step
//     q_next  out N    shift register after this step (new quotient bit in LSB)
// ----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic [N-1:0] q_next
);

  logic [N:0] shifted;
  logic [N:0] diff;
  logic       q_bit;

  assign shifted = {r, q[N-1]};

  adder_subtractor #(
    .W(N + 1)
  ) u_trial_sub (
    .a      (shifted),
    .b      ({1'b0, d}),
    .sub    (1'b1),
    .result (diff)
  );

  assign q_bit = ~diff[N];

  // The kept remainder is always below d, so bit N of either candidate is
  // zero and the remainder fits in N bits.
  assign r_next = q_bit ? diff[N-1:0] : shifted[N-1:0];
  assign q_next = {q[N-2:0], q_bit};

endmodule

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider, one shift-subtract step per clock.
//   Quotient = Dividend / Divisor, Remainder = Dividend % Divisor.
//   A zero divisor skips the iterations and reports Quotient = all ones,
//   Remainder = Dividend and Div_By_Zero = 1.
//   Ports:
//     Clk          in   1  clock, rising edge
//     Rst          in   1  asynchronous active-high reset
//     Start        in   1  request; accepted only in IDLE or DONE
//     Dividend     in   N  numerator, captured on the accepting edge
//     Divisor      in   N  denominator, captured on the accepting edge
//     Busy         out  1  iterations in progress
//     Done         out  1  one-cycle completion pulse
//     Quotient     out  N  result quotient, held until the next completion
//     Remainder    out  N  result remainder, held until the next completion
//     Div_By_Zero  out  1  last completed division had a zero divisor
// ----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Div_By_Zero
);

  localparam int                STEP_W    = cnt_width(N);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

  state_t            state;
  state_t            state_next;

  logic [N-1:0]      r_reg;
  logic [N-1:0]      q_reg;
  logic [N-1:0]      d_reg;
  logic [STEP_W-1:0] step_cnt;

  logic [N-1:0]      r_next;
  logic [N-1:0]      q_next;

  logic              accept;
  logic              last_step;
  logic              divisor_zero;

  assign divisor_zero = (Divisor == '0);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and control decode
  // --------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = divisor_zero ? S_DONE : S_CALC;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_CALC: begin
        if (step_cnt == LAST_STEP) begin
          last_step  = 1'b1;
          state_next = S_DONE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign Busy = (state == S_CALC);
  assign Done = (state == S_DONE);

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
  div_step #(
    .N(N)
  ) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_next),
    .q_next (q_next)
  );

  // Working registers: loaded on acceptance, advanced once per CALC cycle.
  // Start while busy never reaches here, so the running operands are safe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_reg    <= '0;
      q_reg    <= '0;
      d_reg    <= '0;
      step_cnt <= '0;
    end else if (accept) begin
      r_reg    <= '0;
      q_reg    <= Dividend;
      d_reg    <= Divisor;
      step_cnt <= '0;
    end else if (state == S_CALC) begin
      r_reg    <= r_next;
      q_reg    <= q_next;
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: written only on a completion edge, held otherwise.
  // A zero divisor completes on the accepting edge itself; a normal division
  // completes on its last iteration, taking the step outputs directly.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Quotient    <= '0;
      Remainder   <= '0;
      Div_By_Zero <= 1'b0;
    end else if (accept && divisor_zero) begin
      Quotient    <= '1;
      Remainder   <= Dividend;
      Div_By_Zero <= 1'b1;
    end else if (last_step) begin
      Quotient    <= q_next;
      Remainder   <= r_next;
      Div_By_Zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Directed and random checks of seq_divider with N = 8.
//   Inputs change on the falling edge or just after the rising edge;
//   outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int N = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Start;
  logic [N-1:0] Dividend;
  logic [N-1:0] Divisor;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Quotient;
  logic [N-1:0] Remainder;
  logic         Div_By_Zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(
    .N(N)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Busy        (Busy),
    .Done        (Done),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .Div_By_Zero (Div_By_Zero)
  );

  always #5 Clk = ~Clk;

  // Present a request; the next rising edge is E0. Returns just after E0.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    Start    = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Count falling edges after E0 until Done. lat = 0 means it never came.
  task automatic wait_done(output int lat, output int busy_n, output int overlap);
    lat     = 0;
    busy_n  = 0;
    overlap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (Busy) busy_n++;
      if (Busy && Done) overlap++;
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Rst      = 1'b1;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    #12;
    n_tests++;
    if ({Busy, Done, Quotient, Remainder, Div_By_Zero} !== '0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               Busy, Done, Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    n_tests++;
    if ({Busy, Done} !== 2'b00) begin
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", Busy, Done);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    int lat, busy_n, overlap;
    @(negedge Clk);
    start_op(8'd100, 8'd7);
    wait_done(lat, busy_n, overlap);
    n_tests++;
    if (lat != 9) begin
      $display("FAIL basic_latency: got %0d, want 9 (0 = timeout)", lat);
      n_fail++;
    end
    n_tests++;
    if (busy_n != 8) begin
      $display("FAIL basic_busy_cycles: got %0d, want 8", busy_n);
      n_fail++;
    end
    n_tests++;
    if (overlap != 0) begin
      $display("FAIL basic_done_while_busy: got %0d overlapping cycles, want 0", overlap);
      n_fail++;
    end
    n_tests++;
    if ({Quotient, Remainder, Div_By_Zero} !== {8'd14, 8'd2, 1'b0}) begin
      $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b, want q=14 r=2 dbz=0",
               Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
    @(negedge Clk);
    n_tests++;
    if ({Done, Quotient, Remainder} !== {1'b0, 8'd14, 8'd2}) begin
      $display("FAIL basic_hold: got done=%b q=%0d r=%0d, want done=0 q=14 r=2",
               Done, Quotient, Remainder);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n, overlap;
    @(negedge Clk);
    start_op(8'd255, 8'd1);
    wait_done(lat, busy_n, overlap);
    n_tests++;
    if (lat != 9 || {Quotient, Remainder, Div_By_Zero} !== {8'd255, 8'd0, 1'b0}) begin
      $display("FAIL b2b_255_1: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=255 r=0 dbz=0",
               lat, Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
    // Start during the Done cycle.
    start_op(8'd5, 8'd9);
    wait_done(lat, busy_n, overlap);
    n_tests++;
    if (lat != 9 || busy_n != 8) begin
      $display("FAIL b2b_no_gap: got lat=%0d busy=%0d, want lat=9 busy=8", lat, busy_n);
      n_fail++;
    end
    n_tests++;
    if ({Quotient, Remainder, Div_By_Zero} !== {8'd0, 8'd5, 1'b0}) begin
      $display("FAIL b2b_5_9: got q=%0d r=%0d dbz=%b, want q=0 r=5 dbz=0",
               Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
  endtask

  task automatic test_div_by_zero();
    int lat, busy_n, overlap;
    @(negedge Clk);
    start_op(8'd200, 8'd0);
    wait_done(lat, busy_n, overlap);
    n_tests++;
    if (lat != 1 || busy_n != 0) begin
      $display("FAIL dbz_timing: got lat=%0d busy=%0d, want lat=1 busy=0", lat, busy_n);
      n_fail++;
    end
    n_tests++;
    if ({Quotient, Remainder, Div_By_Zero} !== {8'd255, 8'd200, 1'b1}) begin
      $display("FAIL dbz_200_0: got q=%0d r=%0d dbz=%b, want q=255 r=200 dbz=1",
               Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
    @(negedge Clk);
    n_tests++;
    if (Done !== 1'b0) begin
      $display("FAIL dbz_done_width: got done=%b, want 0", Done);
      n_fail++;
    end
    start_op(8'd9, 8'd3);
    wait_done(lat, busy_n, overlap);
    n_tests++;
    if (lat != 9 || {Quotient, Remainder, Div_By_Zero} !== {8'd3, 8'd0, 1'b0}) begin
      $display("FAIL dbz_then_9_3: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=3 r=0 dbz=0",
               lat, Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
  endtask

  task automatic test_start_while_busy();
    int           dones;
    int           done_k;
    logic [N-1:0] q_seen;
    logic [N-1:0] r_seen;
    dones  = 0;
    done_k = 0;
    q_seen = '0;
    r_seen = '0;
    @(negedge Clk);
    start_op(8'd50, 8'd5);
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (Done) begin
        dones++;
        if (done_k == 0) begin
          done_k = k;
          q_seen = Quotient;
          r_seen = Remainder;
        end
      end
      if (k >= 2 && k <= 4) begin
        Start    = 1'b1;
        Dividend = 8'd30 + 8'(k);
        Divisor  = 8'd3;
      end else begin
        Start = 1'b0;
      end
    end
    n_tests++;
    if (dones != 1 || done_k != 9) begin
      $display("FAIL busy_start_done_count: got %0d dones (first at %0d), want 1 at 9",
               dones, done_k);
      n_fail++;
    end
    n_tests++;
    if ({q_seen, r_seen} !== {8'd10, 8'd0}) begin
      $display("FAIL busy_start_50_5: got q=%0d r=%0d, want q=10 r=0", q_seen, r_seen);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    int lat, busy_n, overlap;
    int seen;
    @(negedge Clk);
    start_op(8'd77, 8'd4);
    repeat (3) @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    n_tests++;
    if ({Busy, Done, Quotient, Remainder, Div_By_Zero} !== '0) begin
      $display("FAIL async_reset_now: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               Busy, Done, Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
    repeat (2) @(negedge Clk);
    Rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (Busy || Done) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      $display("FAIL async_reset_idle: got %0d busy/done cycles after reset, want 0", seen);
      n_fail++;
    end
    start_op(8'd77, 8'd4);
    wait_done(lat, busy_n, overlap);
    n_tests++;
    if (lat != 9 || {Quotient, Remainder, Div_By_Zero} !== {8'd19, 8'd1, 1'b0}) begin
      $display("FAIL async_reset_77_4: got lat=%0d q=%0d r=%0d dbz=%b, want lat=9 q=19 r=1 dbz=0",
               lat, Quotient, Remainder, Div_By_Zero);
      n_fail++;
    end
  endtask

  task automatic test_random();
    int           lat, busy_n, overlap;
    int           exp_lat;
    logic [N-1:0] a, b, exp_q, exp_r;
    logic         exp_z;
    @(negedge Clk);
    for (int i = 0; i < 500; i++) begin
      a = N'($urandom_range(255, 0));
      b = ($urandom_range(7, 0) == 0) ? '0 : N'($urandom_range(255, 0));
      if (b == '0) begin
        exp_q   = '1;
        exp_r   = a;
        exp_z   = 1'b1;
        exp_lat = 1;
      end else begin
        exp_q   = a / b;
        exp_r   = a % b;
        exp_z   = 1'b0;
        exp_lat = 9;
      end
      start_op(a, b);
      wait_done(lat, busy_n, overlap);
      n_tests++;
      if (lat != exp_lat || overlap != 0) begin
        $display("FAIL rand_timing[%0d] %0d/%0d: got lat=%0d overlap=%0d, want lat=%0d overlap=0",
                 i, a, b, lat, overlap, exp_lat);
        n_fail++;
      end
      n_tests++;
      if ({Quotient, Remainder, Div_By_Zero} !== {exp_q, exp_r, exp_z}) begin
        $display("FAIL rand_result[%0d] %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                 i, a, b, Quotient, Remainder, Div_By_Zero, exp_q, exp_r, exp_z);
        n_fail++;
      end
      // Either chain the next request into the Done cycle, or let one cycle
      // pass and confirm the pulse was a single cycle wide.
      if ($urandom_range(1, 0) == 0) begin
        @(negedge Clk);
        n_tests++;
        if (Done !== 1'b0) begin
          $display("FAIL rand_done_width[%0d]: got done=%b one cycle later, want 0", i, Done);
          n_fail++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_start_while_busy();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
